// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the instruction fetch unit and the load/store path.
// Round-robin arbitration on conflict, with a watchdog that aborts unacknowledged transactions.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_gnt,
  output logic                    ifu_rvalid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  output logic                    ifu_err,
  input  logic                    lsu_req,
  input  logic                    lsu_wen,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_gnt,
  output logic                    lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    lsu_err,
  output logic                    mem_req,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t                 state_q, state_d;
  owner_t                 owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0]      mem_wmask_q, mem_wmask_d;
  logic                   ifu_rvalid_q, ifu_rvalid_d, ifu_err_q, ifu_err_d;
  logic                   lsu_rvalid_q, lsu_rvalid_d, lsu_err_q, lsu_err_d;
  logic [DATA_WIDTH-1:0]  ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic                   grant_lsu;
  logic [DATA_WIDTH-1:0]  rsp_data;
  logic                   rsp_fire, rsp_err;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    ifu_gnt      = 1'b0;
    lsu_gnt      = 1'b0;
    grant_lsu    = 1'b0;
    rsp_fire     = 1'b0;
    rsp_err      = 1'b0;
    rsp_data     = '0;

    unique case (state_q)
      IDLE: begin
        if (ifu_req || lsu_req) begin
          // On conflict the requester that did not win last time gets the bus.
          grant_lsu = lsu_req && (!ifu_req || owner_q == OWN_IFU);
          if (grant_lsu) begin
            lsu_gnt     = 1'b1;
            owner_d     = OWN_LSU;
            mem_wen_d   = lsu_wen;
            mem_addr_d  = lsu_addr;
            mem_wdata_d = lsu_wdata;
            mem_wmask_d = lsu_wmask;
          end else begin
            ifu_gnt     = 1'b1;
            owner_d     = OWN_IFU;
            mem_wen_d   = 1'b0;
            mem_addr_d  = ifu_addr;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
          end
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (mem_ack) begin
          rsp_fire = 1'b1;
          rsp_data = mem_wen_q ? '0 : mem_rdata;
          state_d  = IDLE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ifu_rvalid_d = rsp_fire && owner_q == OWN_IFU;
    lsu_rvalid_d = rsp_fire && owner_q == OWN_LSU;
    ifu_err_d    = ifu_rvalid_d && rsp_err;
    lsu_err_d    = lsu_rvalid_d && rsp_err;
    ifu_rdata_d  = ifu_rvalid_d ? rsp_data : ifu_rdata_q;
    lsu_rdata_d  = lsu_rvalid_d ? rsp_data : lsu_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_LSU;
      cnt_q        <= '0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      ifu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      ifu_err_q    <= ifu_err_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_err_q    <= lsu_err_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign mem_req    = (state_q == BUSY);
  assign busy       = (state_q == BUSY);
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign ifu_rvalid = ifu_rvalid_q;
  assign ifu_err    = ifu_err_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_err    = lsu_err_q;
  assign lsu_rdata  = lsu_rdata_q;

endmodule
